// File: rtl/i2c_target_regfile.sv
// I2C target with a byte-wide register port: pointer byte first, then auto-incrementing data.
// Optional input glitch filter enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A,
    parameter int         AW          = 4,
    parameter int         FILT_LEN    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_in,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wdata,
    output logic          reg_we,
    input  logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          addr_hit
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_A, PTR, ACK_P,
        WRITE, ACK_W, READ, MACK, IGNORE
    } state_t;

    if (FILT_LEN < 1) begin : g_bad_filt
        $error("FILT_LEN must be at least 1");
    end

    logic [1:0] scl_sync, sda_sync;
    logic       scl_f, sda_f;
    logic       scl_q, sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILT_LEN + 1);
    logic [FW-1:0] scl_cnt, sda_cnt;

    // A line only flips after FILT_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            if (scl_sync[1] == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FW'(FILT_LEN - 1)) begin
                scl_f   <= scl_sync[1];
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_sync[1] == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FW'(FILT_LEN - 1)) begin
                sda_f   <= sda_sync[1];
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end
`else
    assign scl_f = scl_sync[1];
    assign sda_f = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
        end
    end

    logic rise, fall, start, stop;
    assign rise  = scl_f & ~scl_q;
    assign fall  = ~scl_f & scl_q;
    assign start = scl_f & scl_q & sda_q & ~sda_f;
    assign stop  = scl_f & scl_q & ~sda_q & sda_f;

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] shift;
    logic [7:0] byte_next;
    logic       fall_d;
    logic       phase;
    logic       rw;

    assign byte_next = {shift[6:0], sda_f};

    // phase: in ACK states marks that the ACK is being driven;
    // in MACK marks that the master acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            shift     <= '0;
            fall_d    <= 1'b0;
            phase     <= 1'b0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
            addr_hit  <= 1'b0;
        end else begin
            reg_we   <= 1'b0;
            addr_hit <= 1'b0;
            fall_d   <= fall;
            if (start) begin
                state  <= ADDR;
                cnt    <= '0;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                phase  <= 1'b0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    ADDR: begin
                        if (rise) begin
                            shift <= byte_next;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                cnt   <= '0;
                                phase <= 1'b0;
                                if (byte_next[7:1] == TARGET_ADDR) begin
                                    rw       <= byte_next[0];
                                    addr_hit <= 1'b1;
                                    busy     <= 1'b1;
                                    state    <= ACK_A;
                                end else begin
                                    busy  <= 1'b0;
                                    state <= IGNORE;
                                end
                            end
                        end
                    end
                    ACK_A: begin
                        if (fall_d) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                cnt   <= '0;
                                if (rw) begin
                                    shift  <= reg_rdata;
                                    sda_oe <= ~reg_rdata[7];
                                    state  <= READ;
                                end else begin
                                    sda_oe <= 1'b0;
                                    state  <= PTR;
                                end
                            end
                        end
                    end
                    PTR: begin
                        if (rise) begin
                            shift <= byte_next;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                cnt      <= '0;
                                phase    <= 1'b0;
                                reg_addr <= byte_next[AW-1:0];
                                state    <= ACK_P;
                            end
                        end
                    end
                    ACK_P, ACK_W: begin
                        if (fall_d) begin
                            if (!phase) begin
                                sda_oe <= 1'b1;
                                phase  <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                phase  <= 1'b0;
                                cnt    <= '0;
                                state  <= WRITE;
                                if (state == ACK_W) begin
                                    reg_addr <= reg_addr + 1'b1;
                                end
                            end
                        end
                    end
                    WRITE: begin
                        if (rise) begin
                            shift <= byte_next;
                            cnt   <= cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                cnt       <= '0;
                                phase     <= 1'b0;
                                reg_wdata <= byte_next;
                                reg_we    <= 1'b1;
                                state     <= ACK_W;
                            end
                        end
                    end
                    READ: begin
                        if (rise && cnt != 4'd8) begin
                            cnt <= cnt + 4'd1;
                        end
                        if (fall_d) begin
                            if (cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                phase  <= 1'b0;
                                state  <= MACK;
                            end else begin
                                shift  <= {shift[6:0], 1'b0};
                                sda_oe <= ~shift[6];
                            end
                        end
                    end
                    MACK: begin
                        if (rise) begin
                            if (!sda_f) begin
                                reg_addr <= reg_addr + 1'b1;
                                phase    <= 1'b1;
                            end else begin
                                busy  <= 1'b0;
                                state <= IGNORE;
                            end
                        end else if (fall_d && phase) begin
                            shift  <= reg_rdata;
                            sda_oe <= ~reg_rdata[7];
                            cnt    <= '0;
                            phase  <= 1'b0;
                            state  <= READ;
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bus-level master model, write scoreboard on reg_we.
// Define I2C_GLITCH_FILTER_EN to also exercise the SCL glitch filter.
module tb_i2c_target_regfile;

    localparam int AW = 4;
    localparam int Q  = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl_m = 1'b1;
    logic          sda_m = 1'b1;
    logic          sda_line;
    logic          sda_oe;
    logic [AW-1:0] reg_addr;
    logic [7:0]    reg_wdata;
    logic          reg_we;
    logic [7:0]    reg_rdata;
    logic          busy;
    logic          addr_hit;

    always #5 clk = ~clk;

    assign sda_line  = sda_m & ~sda_oe;
    assign reg_rdata = 8'h80 + 8'(reg_addr);

    i2c_target_regfile #(
        .TARGET_ADDR(7'h2A),
        .AW(AW),
        .FILT_LEN(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .scl_in(scl_m),
        .sda_in(sda_line),
        .sda_oe(sda_oe),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_we(reg_we),
        .reg_rdata(reg_rdata),
        .busy(busy),
        .addr_hit(addr_hit)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    wr_t  exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   hit_cnt = 0;
    logic oe_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        wr_t e;
        if (!rst) begin
            if (addr_hit) hit_cnt++;
            if (sda_oe) oe_seen = 1'b1;
            if (reg_we) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_we", 32'(reg_we), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("we_addr", 32'(reg_addr), 32'(e.a));
                    check("we_data", 32'(reg_wdata), 32'(e.d));
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_c();
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b0;
    endtask

    task automatic stop_c();
        #Q sda_m = 1'b0;
        #Q scl_m = 1'b1;
        #Q sda_m = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        #Q sda_m = b;
        #Q scl_m = 1'b1;
        if (glitch) begin
            #Q scl_m = 1'b0;
            #10 scl_m = 1'b1;
            #(Q - 10);
        end else begin
            #(2 * Q);
        end
        scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gbit,
                             output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i], i == gbit);
        #Q sda_m = 1'b1;
        #Q scl_m = 1'b1;
        #Q ack = sda_line;
        #Q scl_m = 1'b0;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        b = '0;
        for (int i = 0; i < 8; i++) begin
            #Q sda_m = 1'b1;
            #Q scl_m = 1'b1;
            #Q b = {b[6:0], sda_line};
            #Q scl_m = 1'b0;
        end
        #Q sda_m = mack;
        #Q scl_m = 1'b1;
        #(2 * Q) scl_m = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic       ack;
        logic [7:0] b;
        logic [7:0] a8;

        clks(3);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_reg_we", 32'(reg_we), 32'd0);
        check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
        check("rst_reg_addr", 32'(reg_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_addr_hit", 32'(addr_hit), 32'd0);
        rst = 1'b0;
        clks(4);

        // write 0xEB to register 3
        start_c();
        send_byte(8'h54, -1, ack);
        check("t1_ack_addr", 32'(ack), 32'd0);
        check("t1_hit_cnt", 32'(hit_cnt), 32'd1);
        check("t1_busy_on", 32'(busy), 32'd1);
        send_byte(8'h03, -1, ack);
        check("t1_ack_ptr", 32'(ack), 32'd0);
        exp_q.push_back('{a: 4'h3, d: 8'hEB});
        send_byte(8'hEB, -1, ack);
        check("t1_ack_data", 32'(ack), 32'd0);
        stop_c();
        clks(4);
        check("t1_busy_off", 32'(busy), 32'd0);
        check("t1_we_seen", 32'(exp_q.size()), 32'd0);

        // foreign address is ignored
        oe_seen = 1'b0;
        start_c();
        send_byte(8'h56, -1, ack);
        check("t2_nack_addr", 32'(ack), 32'd1);
        send_byte(8'h12, -1, ack);
        check("t2_nack_data", 32'(ack), 32'd1);
        stop_c();
        clks(4);
        check("t2_no_oe", 32'(oe_seen), 32'd0);
        check("t2_hit_cnt", 32'(hit_cnt), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);

        // pointer wrap from 0xF to 0x0
        exp_q.push_back('{a: 4'hF, d: 8'h11});
        exp_q.push_back('{a: 4'h0, d: 8'h22});
        start_c();
        send_byte(8'h54, -1, ack);
        send_byte(8'h0F, -1, ack);
        send_byte(8'h11, -1, ack);
        check("t3_ack_d0", 32'(ack), 32'd0);
        send_byte(8'h22, -1, ack);
        check("t3_ack_d1", 32'(ack), 32'd0);
        stop_c();
        clks(4);
        check("t3_we_seen", 32'(exp_q.size()), 32'd0);
        check("t3_reg_addr", 32'(reg_addr), 32'd1);

        // pointer 5, repeated START, read two bytes
        start_c();
        send_byte(8'h54, -1, ack);
        send_byte(8'h05, -1, ack);
        start_c();
        send_byte(8'h55, -1, ack);
        check("t4_ack_rd", 32'(ack), 32'd0);
        check("t4_hit_cnt", 32'(hit_cnt), 32'd4);
        recv_byte(1'b0, b);
        check("t4_byte0", 32'(b), 32'h85);
        recv_byte(1'b1, b);
        check("t4_byte1", 32'(b), 32'h86);
        clks(8);
        check("t4_sda_rel", 32'(sda_oe), 32'd0);
        check("t4_busy_nack", 32'(busy), 32'd0);
        check("t4_reg_addr", 32'(reg_addr), 32'd6);
        stop_c();

        // pointer-only write
        start_c();
        send_byte(8'h54, -1, ack);
        send_byte(8'h09, -1, ack);
        stop_c();
        clks(4);
        check("t5_reg_addr", 32'(reg_addr), 32'd9);

        // STOP cut into a data byte
        start_c();
        send_byte(8'h54, -1, ack);
        send_byte(8'h07, -1, ack);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        stop_c();
        clks(4);
        check("t6_sda_oe", 32'(sda_oe), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_reg_addr", 32'(reg_addr), 32'd7);

`ifdef I2C_GLITCH_FILTER_EN
        // SCL low glitch inside a data byte
        exp_q.push_back('{a: 4'h2, d: 8'hA5});
        start_c();
        send_byte(8'h54, -1, ack);
        send_byte(8'h02, -1, ack);
        send_byte(8'hA5, 4, ack);
        check("t7_ack_data", 32'(ack), 32'd0);
        stop_c();
        clks(4);
        check("t7_we_seen", 32'(exp_q.size()), 32'd0);
`endif

        // reset while the address ACK is driven
        start_c();
        a8 = 8'h54;
        for (int i = 7; i >= 0; i--) send_bit(a8[i], 1'b0);
        #Q sda_m = 1'b1;
        for (int i = 0; i < 40 && !sda_oe; i++) @(negedge clk);
        check("t8_ack_driven", 32'(sda_oe), 32'd1);
        #2 rst = 1'b1;
        #1 check("t8_async_rel", 32'(sda_oe), 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(4);
        check("t8_busy", 32'(busy), 32'd0);
        check("t8_reg_addr", 32'(reg_addr), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
